// File: rtl/perceptron_full_unit.sv
// Single trainable neuron: weighted sum + bias -> activation, local backprop delta,
// and one SGD weight/bias step per clock while training. Simulation-only real datapath.
package common_pkg;
  typedef enum logic [1:0] {
    SIGMOID = 2'd0,
    RELU    = 2'd1,
    TANH    = 2'd2,
    LINEAR  = 2'd3
  } act_func;
endpackage

module perceptron_full_unit
  import common_pkg::*;
#(
  parameter int unsigned input_units  = 2,
  parameter int unsigned output_units = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  real     values [input_units],
  input  act_func activation,
  input  logic    training,
  input  real     learning_rate,
  input  real     next_layer_weights [output_units],
  input  real     error_gradient_next_layer [output_units],
  output real     prediction,
  output real     error_gradient,
  output real     current_weights [input_units]
);

  real w [input_units];
  real b;
  real w_nxt [input_units];
  real b_nxt;
  real z;
  real p;
  real d_out;
  real deriv;

  // Forward pass and local delta
  always_comb begin
    z     = b;
    d_out = 0.0;
    p     = 0.0;
    deriv = 1.0;
    for (int i = 0; i < int'(input_units); i++) begin
      z = z + w[i] * values[i];
    end
    for (int k = 0; k < int'(output_units); k++) begin
      d_out = d_out + next_layer_weights[k] * error_gradient_next_layer[k];
    end
    case (activation)
      SIGMOID: begin
        p     = 1.0 / (1.0 + $exp(-z));
        deriv = p * (1.0 - p);
      end
      RELU: begin
        p     = (z > 0.0) ? z : 0.0;
        deriv = (z > 0.0) ? 1.0 : 0.0;
      end
      TANH: begin
        p     = $tanh(z);
        deriv = 1.0 - p * p;
      end
      default: begin
        p     = z;
        deriv = 1.0;
      end
    endcase
  end

  assign prediction     = p;
  assign error_gradient = d_out * deriv;

  // SGD step candidates
  always_comb begin
    b_nxt = b - learning_rate * error_gradient;
    for (int i = 0; i < int'(input_units); i++) begin
      w_nxt[i] = w[i] - learning_rate * error_gradient * values[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w <= '{default: 0.0};
      b <= 0.0;
    end else if (training) begin
      w <= w_nxt;
      b <= b_nxt;
    end
  end

  assign current_weights = w;

endmodule

// File: tb/tb_perceptron_full_unit.sv
// Self-checking bench for perceptron_full_unit: directed spec cases, randomized steps
// against a plain-arithmetic neuron model, and AND-gate learning.
module tb_perceptron_full_unit;
  import common_pkg::*;

  logic    clk;
  logic    rst;
  real     x [2];
  act_func act;
  logic    training;
  real     lr;
  real     nw [1];
  real     egn [1];
  real     prediction;
  real     error_gradient;
  real     current_weights [2];

  int n_checks = 0;
  int n_errors = 0;

  real mw [2];
  real mb;
  real mg;

  perceptron_full_unit #(.input_units(2), .output_units(1)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .values                    (x),
    .activation                (act),
    .training                  (training),
    .learning_rate             (lr),
    .next_layer_weights        (nw),
    .error_gradient_next_layer (egn),
    .prediction                (prediction),
    .error_gradient            (error_gradient),
    .current_weights           (current_weights)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic real f_act(input act_func a, input real zz);
    case (a)
      SIGMOID: return 1.0 / (1.0 + $exp(-zz));
      RELU:    return (zz > 0.0) ? zz : 0.0;
      TANH:    return $tanh(zz);
      default: return zz;
    endcase
  endfunction

  function automatic real f_der(input act_func a, input real zz);
    real pp;
    pp = f_act(a, zz);
    case (a)
      SIGMOID: return pp * (1.0 - pp);
      RELU:    return (zz > 0.0) ? 1.0 : 0.0;
      TANH:    return 1.0 - pp * pp;
      default: return 1.0;
    endcase
  endfunction

  function automatic real model_z(input real x0, input real x1);
    return mb + mw[0] * x0 + mw[1] * x1;
  endfunction

  function automatic real rnd(input real lo, input real hi);
    return lo + (hi - lo) * (real'($urandom_range(0, 10000)) / 10000.0);
  endfunction

  task automatic chk(input string tag, input real obs, input real exp_v);
    real tol;
    tol = 1e-9 * (1.0 + ((exp_v < 0.0) ? -exp_v : exp_v));
    n_checks++;
    assert ((obs - exp_v) <= tol && (exp_v - obs) <= tol) else begin
      n_errors++;
      $error("FAIL %s: observed=%0.9f expected=%0.9f", tag, obs, exp_v);
    end
  endtask

  task automatic chk_true(input string tag, input bit obs);
    n_checks++;
    assert (obs === 1'b1) else begin
      n_errors++;
      $error("FAIL %s: observed=%0b expected=1", tag, obs);
    end
  endtask

  task automatic chk_weights(input string tag);
    chk({tag, "_w0"}, current_weights[0], mw[0]);
    chk({tag, "_w1"}, current_weights[1], mw[1]);
  endtask

  // Drive inputs and check the combinational forward/backward outputs
  task automatic apply(input string tag, input act_func a, input real x0, input real x1,
                       input real nw0, input real eg0, input real lr_v, input logic tr);
    real zz;
    act = a; x[0] = x0; x[1] = x1; nw[0] = nw0; egn[0] = eg0; lr = lr_v; training = tr;
    #1;
    zz = model_z(x0, x1);
    mg = nw0 * eg0 * f_der(a, zz);
    chk({tag, "_pred"}, prediction, f_act(a, zz));
    chk({tag, "_grad"}, error_gradient, mg);
  endtask

  // One rising edge; model applies the SGD step on the values sampled before it
  task automatic edge_step();
    real x0, x1, l;
    logic tr;
    x0 = x[0]; x1 = x[1]; l = lr; tr = training;
    @(posedge clk);
    #1;
    if (tr && !rst) begin
      mw[0] = mw[0] - l * mg * x0;
      mw[1] = mw[1] - l * mg * x1;
      mb    = mb - l * mg;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    mw[0] = 0.0; mw[1] = 0.0; mb = 0.0;
    rst = 1'b0;
  endtask

  real cost, cost_first, cost_last, y, pm, pe [4];

  initial begin
    rst = 1'b1; training = 1'b0; lr = 0.0; act = SIGMOID;
    x[0] = 0.7; x[1] = -1.3; nw[0] = 0.0; egn[0] = 0.0;
    mw[0] = 0.0; mw[1] = 0.0; mb = 0.0;
    #3;
    // Reset state, Sigmoid -> 0.5
    chk("rst_w0", current_weights[0], 0.0);
    chk("rst_w1", current_weights[1], 0.0);
    chk("rst_pred", prediction, 0.5);
    @(negedge clk);
    rst = 1'b0;

    // Sigmoid step
    apply("sig", SIGMOID, 1.0, 1.0, 1.0, -2.0, 1.0, 1'b1);
    chk("sig_grad_const", error_gradient, -0.5);
    edge_step();
    chk("sig_w0_const", current_weights[0], 0.5);
    chk("sig_w1_const", current_weights[1], 0.5);
    chk("sig_pred_after", prediction, 1.0 / (1.0 + $exp(-1.5)));

    // Hold with training low
    apply("hold", SIGMOID, 0.8, -0.4, 1.5, 2.0, 0.7, 1'b0);
    for (int i = 0; i < 3; i++) edge_step();
    chk_weights("hold");
    chk("hold_w0_const", current_weights[0], 0.5);

    // Asynchronous reset mid-training, no clock edge
    apply("pre_rst", TANH, 0.3, 0.9, -1.0, 0.6, 0.5, 1'b1);
    edge_step();
    chk_weights("pre_rst");
    rst = 1'b1;
    #1;
    mw[0] = 0.0; mw[1] = 0.0; mb = 0.0;
    chk("async_rst_w0", current_weights[0], 0.0);
    chk("async_rst_w1", current_weights[1], 0.0);
    edge_step();
    chk_weights("rst_held");
    rst = 1'b0;

    // Linear step
    do_reset();
    apply("lin", LINEAR, 2.0, 0.0, 3.0, 1.0, 0.1, 1'b1);
    chk("lin_grad_const", error_gradient, 3.0);
    edge_step();
    chk("lin_w0_const", current_weights[0], -0.6);
    chk("lin_w1_const", current_weights[1], 0.0);
    chk("lin_pred_after", prediction, -1.5);

    // ReLU at z == 0 gives zero derivative
    do_reset();
    apply("relu0", RELU, 1.0, 1.0, 1.0, 5.0, 1.0, 1'b1);
    chk("relu0_grad_const", error_gradient, 0.0);
    edge_step();
    chk("relu0_w0", current_weights[0], 0.0);
    chk("relu0_w1", current_weights[1], 0.0);

    // Randomized steps vs model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      apply("rnd", act_func'(2'($urandom_range(0, 3))), rnd(-1.0, 1.0), rnd(-1.0, 1.0),
            rnd(-1.5, 1.5), rnd(-1.0, 1.0), rnd(0.0, 0.5), 1'($urandom_range(0, 1)));
      edge_step();
      chk_weights("rnd");
    end

    // AND learning with BCE gradient
    do_reset();
    cost_first = 0.0; cost_last = 0.0;
    for (int ep = 1; ep <= 5; ep++) begin
      cost = 0.0;
      for (int pat = 0; pat < 4; pat++) begin
        x[0] = (pat == 0 || pat == 1) ? 1.0 : 0.0;
        x[1] = (pat == 0 || pat == 2) ? 1.0 : 0.0;
        y    = (pat == 0) ? 1.0 : 0.0;
        pm   = f_act(SIGMOID, model_z(x[0], x[1]));
        apply("and", SIGMOID, x[0], x[1], 1.0, -(y / pm - (1.0 - y) / (1.0 - pm)), 1.0, 1'b1);
        cost = cost - (y * $ln(prediction) + (1.0 - y) * $ln(1.0 - prediction));
        edge_step();
        chk_weights("and");
      end
      if (ep == 1) cost_first = cost;
      if (ep == 5) cost_last = cost;
    end
    chk_true("and_cost_decrease", cost_last < cost_first);
    for (int pat = 0; pat < 4; pat++) begin
      apply("and_eval", SIGMOID, (pat == 0 || pat == 1) ? 1.0 : 0.0,
            (pat == 0 || pat == 2) ? 1.0 : 0.0, 1.0, 0.0, 1.0, 1'b0);
      pe[pat] = prediction;
    end
    chk_true("and_11_gt_10", pe[0] > pe[1]);
    chk_true("and_11_gt_01", pe[0] > pe[2]);
    chk_true("and_11_gt_00", pe[0] > pe[3]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
